// File: rtl/phys_regfile_n_pkg.sv
// rtl/phys_regfile_n_pkg.sv - shared core sizing defaults and physical register index type
package phys_regfile_n_pkg;

   localparam int DEF_NUM_PREGS = 128;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_N_WR      = 3;
   localparam int DEF_N_RD      = 6;
   localparam int DEF_N_CHK     = 6;
   localparam int DEF_N_ALLOC   = 2;
   localparam int DEF_PREG_W    = $clog2(DEF_NUM_PREGS);

   typedef logic [DEF_PREG_W-1:0] preg_t;

endpackage

// File: rtl/phys_regfile_n_ready_table.sv
// rtl/phys_regfile_n_ready_table.sv - per-preg ready bits with allocate/writeback/flush priority merge
module ready_table
   import phys_regfile_n_pkg::*;
#(
   parameter int NUM_PREGS = DEF_NUM_PREGS,
   parameter int PREG_W    = $clog2(NUM_PREGS),
   parameter int N_WR      = DEF_N_WR,
   parameter int N_CHK     = DEF_N_CHK,
   parameter int N_ALLOC   = DEF_N_ALLOC
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [N_WR-1:0]                  write_en,
   input  logic [N_WR-1:0][PREG_W-1:0]      write_preg,
   input  logic [N_ALLOC-1:0]               set_not_rdy,
   input  logic [N_ALLOC-1:0][PREG_W-1:0]   set_not_rdy_preg,
   input  logic                             flush,
   input  logic [NUM_PREGS-1:0]             flush_rdy_mask,
   input  logic [N_CHK-1:0][PREG_W-1:0]     check_preg,
   output logic [N_CHK-1:0]                 check_rdy
);

   logic [NUM_PREGS-1:0] rdy_q;
   logic [NUM_PREGS-1:0] rdy_d;

   // Next table: flush mask lowest, writebacks over it, allocations win; preg 0 pinned ready
   always_comb begin
      rdy_d = rdy_q;
      if (flush) begin
         rdy_d = rdy_d | flush_rdy_mask;
      end
      for (int k = 0; k < N_WR; k++) begin
         if (write_en[k]) begin
            rdy_d[write_preg[k]] = 1'b1;
         end
      end
      for (int a = 0; a < N_ALLOC; a++) begin
         if (set_not_rdy[a]) begin
            rdy_d[set_not_rdy_preg[a]] = 1'b0;
         end
      end
      rdy_d[0] = 1'b1;
   end

   // Ready table register; reset marks every preg ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_q <= '1;
      end else begin
         rdy_q <= rdy_d;
      end
   end

   // Ready query sees same-cycle writebacks and allocations with the same priority as the table
   always_comb begin
      check_rdy = '0;
      for (int c = 0; c < N_CHK; c++) begin
         check_rdy[c] = rdy_q[check_preg[c]];
         for (int k = 0; k < N_WR; k++) begin
            if (write_en[k] && (write_preg[k] == check_preg[c])) begin
               check_rdy[c] = 1'b1;
            end
         end
         for (int a = 0; a < N_ALLOC; a++) begin
            if (set_not_rdy[a] && (set_not_rdy_preg[a] == check_preg[c])) begin
               check_rdy[c] = 1'b0;
            end
         end
         if (check_preg[c] == '0) begin
            check_rdy[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/phys_regfile_n.sv
// rtl/phys_regfile_n.sv - multi-ported physical register file with bypass, ready table and wakeup
module phys_regfile_n
   import phys_regfile_n_pkg::*;
#(
   parameter int NUM_PREGS = DEF_NUM_PREGS,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int N_WR      = DEF_N_WR,
   parameter int N_RD      = DEF_N_RD,
   parameter int N_CHK     = DEF_N_CHK,
   parameter int N_ALLOC   = DEF_N_ALLOC,
   parameter int PREG_W    = $clog2(NUM_PREGS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [N_WR-1:0]                  write_en,
   input  logic [N_WR-1:0][PREG_W-1:0]      write_preg,
   input  logic [N_WR-1:0][DATA_W-1:0]      write_data,
   input  logic [N_RD-1:0][PREG_W-1:0]      read_preg,
   output logic [N_RD-1:0][DATA_W-1:0]      read_data,
   input  logic [N_CHK-1:0][PREG_W-1:0]     check_preg,
   output logic [N_CHK-1:0]                 check_rdy,
   input  logic [N_ALLOC-1:0]               set_not_rdy,
   input  logic [N_ALLOC-1:0][PREG_W-1:0]   set_not_rdy_preg,
   input  logic                             flush,
   input  logic [NUM_PREGS-1:0]             flush_rdy_mask,
   output logic [N_WR-1:0]                  rdy_valid,
   output logic [N_WR-1:0][PREG_W-1:0]      rdy_preg,
   output logic                             collision_err
);

   logic [DATA_W-1:0] mem [NUM_PREGS];
   logic [N_WR-1:0]   wake;
   logic              dup_write;

   ready_table #(
      .NUM_PREGS (NUM_PREGS),
      .PREG_W    (PREG_W),
      .N_WR      (N_WR),
      .N_CHK     (N_CHK),
      .N_ALLOC   (N_ALLOC)
   ) u_ready_table (
      .clk              (clk),
      .reset            (reset),
      .write_en         (write_en),
      .write_preg       (write_preg),
      .set_not_rdy      (set_not_rdy),
      .set_not_rdy_preg (set_not_rdy_preg),
      .flush            (flush),
      .flush_rdy_mask   (flush_rdy_mask),
      .check_preg       (check_preg),
      .check_rdy        (check_rdy)
   );

   // A port wakes only if it is the highest-index writer of a nonzero preg not being reallocated
   always_comb begin
      wake = '0;
      for (int k = 0; k < N_WR; k++) begin
         wake[k] = write_en[k] && (write_preg[k] != '0);
         for (int j = k + 1; j < N_WR; j++) begin
            if (write_en[j] && (write_preg[j] == write_preg[k])) begin
               wake[k] = 1'b0;
            end
         end
         for (int a = 0; a < N_ALLOC; a++) begin
            if (set_not_rdy[a] && (set_not_rdy_preg[a] == write_preg[k])) begin
               wake[k] = 1'b0;
            end
         end
      end
   end

   // Detect two enabled writers aimed at the same nonzero preg
   always_comb begin
      dup_write = 1'b0;
      for (int k = 1; k < N_WR; k++) begin
         for (int j = 0; j < k; j++) begin
            if (write_en[k] && write_en[j] && (write_preg[k] == write_preg[j]) &&
                (write_preg[k] != '0)) begin
               dup_write = 1'b1;
            end
         end
      end
   end

   // Data array; later ports overwrite earlier ones so the highest index commits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PREGS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int k = 0; k < N_WR; k++) begin
            if (write_en[k] && (write_preg[k] != '0)) begin
               mem[write_preg[k]] <= write_data[k];
            end
         end
      end
   end

   // Registered wakeup broadcast and sticky collision flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_valid     <= '0;
         rdy_preg      <= '0;
         collision_err <= 1'b0;
      end else begin
         rdy_valid <= wake;
         for (int k = 0; k < N_WR; k++) begin
            if (wake[k]) begin
               rdy_preg[k] <= write_preg[k];
            end
         end
         if (dup_write) begin
            collision_err <= 1'b1;
         end
      end
   end

   // Combinational read with write-to-read bypass, highest matching writer last; preg 0 is zero
   always_comb begin
      read_data = '0;
      for (int r = 0; r < N_RD; r++) begin
         read_data[r] = mem[read_preg[r]];
         for (int k = 0; k < N_WR; k++) begin
            if (write_en[k] && (write_preg[k] == read_preg[r])) begin
               read_data[r] = write_data[k];
            end
         end
         if (read_preg[r] == '0) begin
            read_data[r] = '0;
         end
      end
   end

endmodule

// File: doc/phys_regfile_n.md
PHYS_REGFILE_N -- requirements
Module: phys_regfile_n

Interface
REQ-001 SHALL have parameters: NUM_PREGS, default 128, number of physical registers; DATA_W, default 32, register width; N_WR, default 3, writeback ports; N_RD, default 6, data read ports; N_CHK, default 6, ready-check ports; N_ALLOC, default 2, set-not-ready ports; PREG_W = $clog2(NUM_PREGS), derived.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- write_en  in  N_WR  per-port writeback valid
- write_preg  in  N_WR x PREG_W  writeback destination
- write_data  in  N_WR x DATA_W  writeback value
- read_preg  in  N_RD x PREG_W  read source
- read_data  out  N_RD x DATA_W  read value
- check_preg  in  N_CHK x PREG_W  ready-query register
- check_rdy  out  N_CHK  ready-query result
- set_not_rdy  in  N_ALLOC  per-port allocation valid from rename
- set_not_rdy_preg  in  N_ALLOC x PREG_W  newly allocated destination
- flush  in  1  recovery strobe
- flush_rdy_mask  in  NUM_PREGS  registers forced ready on flush
- rdy_valid  out  N_WR  registered wakeup broadcast valid
- rdy_preg  out  N_WR x PREG_W  registered wakeup register
- collision_err  out  1  sticky same-cycle duplicate-write flag

Function
REQ-003 Storage SHALL be NUM_PREGS x DATA_W data plus a NUM_PREGS-bit ready table, both updated only on rising clk.
REQ-004 Preg 0 SHALL read 0, report ready, ignore writes and set_not_rdy, and never produce a wakeup.
REQ-005 read_data SHALL be combinational, zero latency; every read port is independent of every other port (no cross-port enable aliasing).
REQ-006 A read of a preg being written in the same cycle SHALL return write_data (write-to-read bypass); multiple matching writers resolve to the highest port index.
REQ-007 check_rdy SHALL be combinational: 1 if table bit set or any same-cycle write_en targets that preg, overridden to 0 if a same-cycle set_not_rdy targets it.
REQ-008 Write on port k with preg != 0 SHALL store data, set the ready bit, and next cycle drive rdy_valid[k]=1, rdy_preg[k]=preg; otherwise rdy_valid[k]=0 next cycle (rdy_preg holds).
REQ-009 set_not_rdy with preg != 0 SHALL clear the ready bit at the next edge.
REQ-010 Same-cycle priority on a ready bit: set_not_rdy > write > flush mask; set_not_rdy on the written preg SHALL suppress that port's wakeup, data still written.
REQ-011 flush SHALL set every ready bit whose mask bit is 1 and leave others unchanged; no data change, no wakeups generated by flush.
REQ-012 Two or more write ports targeting the same nonzero preg in one cycle SHALL commit the highest port index data, emit wakeup only on that port, and set collision_err=1 until reset.
REQ-013 All per-port behaviour SHALL scale with N_WR/N_RD/N_CHK/N_ALLOC from 1 to 8 without RTL edits.

Reset
REQ-014 Asserting reset SHALL immediately force: all data 0, all ready bits 1, rdy_valid 0, rdy_preg 0, collision_err 0, regardless of clk.
REQ-015 Writes, set_not_rdy and flush presented while reset is high SHALL be discarded; the first edge after deassertion operates normally.

Structure
REQ-016 The default parameters, PREG_W derivation and a preg index typedef SHALL live in the shared core package used by rename and reservation stations.
REQ-017 The ready table with its priority merge SHALL be a sub-module ready_table; data array, bypass and wakeup registers stay in phys_regfile_n.

Verification
REQ-018 Reset then read preg 5 and check preg 5 -> read_data 0, check_rdy 1; collision_err 0.
REQ-019 write port0 preg 10=0xDEADBEEF while read port3 reads 10 -> same-cycle read_data 0xDEADBEEF; next cycle rdy_valid[0]=1, rdy_preg[0]=10.
REQ-020 set_not_rdy preg 20, next cycle check 20 -> 0; write port2 preg 20=7 -> same-cycle check 1, next cycle table 1, rdy_valid[2]=1.
REQ-021 Same cycle set_not_rdy 30 and write port1 preg 30=0x55 -> ready 0 afterwards, read 0x55, rdy_valid[1]=0.
REQ-022 Ports 0 and 2 write preg 40 with 1 and 2 -> read 2, only rdy_valid[2]=1, collision_err stays 1; write preg 0=9 -> read 0, no wakeup.
REQ-023 Clear 50 and 51, flush with mask bit 50 only -> check 50=1, 51=0; async reset mid-sequence -> all outputs at reset values before next clk.
